// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the 12-bit peripheral memory bus.
// It carries one transaction at a time and aborts a read whose downstream response never arrives.
module mem_arbiter #(
  parameter int unsigned RSP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_,

  input  logic        req0_cmd_valid,
  output logic        req0_cmd_ready,
  input  logic        req0_cmd_wr,
  input  logic [11:0] req0_cmd_addr,
  input  logic [31:0] req0_cmd_wdata,
  output logic        req0_rsp_valid,
  output logic [31:0] req0_rsp_rdata,
  output logic        req0_rsp_err,

  input  logic        req1_cmd_valid,
  output logic        req1_cmd_ready,
  input  logic        req1_cmd_wr,
  input  logic [11:0] req1_cmd_addr,
  input  logic [31:0] req1_cmd_wdata,
  output logic        req1_rsp_valid,
  output logic [31:0] req1_rsp_rdata,
  output logic        req1_rsp_err,

  output logic        mem_cmd_valid,
  output logic        mem_cmd_wr,
  output logic [11:0] mem_cmd_addr,
  output logic [31:0] mem_cmd_wdata,
  input  logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  localparam logic [8:0] TIMEOUT_LIMIT = 9'(RSP_TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic        owner;
  logic [7:0]  wait_cnt;
  logic        winner;
  logic        accept;
  logic        timeout;
  logic        rsp_done;

  // On a tie the requester that did not win last time is served.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = 1'b0;
    if (req0_cmd_valid && req1_cmd_valid) begin
      winner = ~last_grant;
    end else if (req1_cmd_valid) begin
      winner = 1'b1;
    end
  end

  assign accept         = (state == IDLE) && (req0_cmd_valid || req1_cmd_valid);
  assign req0_cmd_ready = accept && !winner;
  assign req1_cmd_ready = accept &&  winner;
  assign mem_cmd_valid  = (state == ISSUE);

  // Abort fires in the WAIT_RSP cycle that places the error response RSP_TIMEOUT cycles after ISSUE.
  assign timeout  = (state == WAIT_RSP) && !mem_rsp_ready &&
                    (({1'b0, wait_cnt} + 9'd2) >= TIMEOUT_LIMIT);
  assign rsp_done = (state == WAIT_RSP) && (mem_rsp_ready || timeout);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (accept) state_next = ISSUE;
      ISSUE:    state_next = mem_cmd_wr ? IDLE : WAIT_RSP;
      WAIT_RSP: if (rsp_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      wait_cnt      <= '0;
      mem_cmd_wr    <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_wdata <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner         <= winner;
        last_grant    <= winner;
        mem_cmd_wr    <= winner ? req1_cmd_wr    : req0_cmd_wr;
        mem_cmd_addr  <= winner ? req1_cmd_addr  : req0_cmd_addr;
        mem_cmd_wdata <= winner ? req1_cmd_wdata : req0_cmd_wdata;
      end
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if ((state == WAIT_RSP) && !mem_rsp_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Response data and error flag persist per requester until that requester's next response.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      req0_rsp_valid <= 1'b0;
      req0_rsp_rdata <= '0;
      req0_rsp_err   <= 1'b0;
      req1_rsp_valid <= 1'b0;
      req1_rsp_rdata <= '0;
      req1_rsp_err   <= 1'b0;
    end else begin
      req0_rsp_valid <= 1'b0;
      req1_rsp_valid <= 1'b0;
      if (rsp_done && !owner) begin
        req0_rsp_valid <= 1'b1;
        req0_rsp_rdata <= mem_rsp_ready ? mem_rsp_rdata : 32'h0;
        req0_rsp_err   <= !mem_rsp_ready;
      end
      if (rsp_done && owner) begin
        req1_rsp_valid <= 1'b1;
        req1_rsp_rdata <= mem_rsp_ready ? mem_rsp_rdata : 32'h0;
        req1_rsp_err   <= !mem_rsp_ready;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grants, commands and responses.
// A separate monitor compares them against what the DUT presents.
module tb_mem_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        req0_cmd_valid = 1'b0, req0_cmd_wr = 1'b0;
  logic [11:0] req0_cmd_addr = '0;
  logic [31:0] req0_cmd_wdata = '0;
  logic        req1_cmd_valid = 1'b0, req1_cmd_wr = 1'b0;
  logic [11:0] req1_cmd_addr = '0;
  logic [31:0] req1_cmd_wdata = '0;
  logic        req0_cmd_ready, req0_rsp_valid, req0_rsp_err;
  logic        req1_cmd_ready, req1_rsp_valid, req1_rsp_err;
  logic [31:0] req0_rsp_rdata, req1_rsp_rdata;
  logic        mem_cmd_valid, mem_cmd_wr;
  logic [11:0] mem_cmd_addr;
  logic [31:0] mem_cmd_wdata;
  logic        mem_rsp_ready = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;

  mem_arbiter #(.RSP_TIMEOUT(TO)) dut (
    .clk(clk), .reset_(reset_),
    .req0_cmd_valid(req0_cmd_valid), .req0_cmd_ready(req0_cmd_ready), .req0_cmd_wr(req0_cmd_wr),
    .req0_cmd_addr(req0_cmd_addr), .req0_cmd_wdata(req0_cmd_wdata), .req0_rsp_valid(req0_rsp_valid),
    .req0_rsp_rdata(req0_rsp_rdata), .req0_rsp_err(req0_rsp_err),
    .req1_cmd_valid(req1_cmd_valid), .req1_cmd_ready(req1_cmd_ready), .req1_cmd_wr(req1_cmd_wr),
    .req1_cmd_addr(req1_cmd_addr), .req1_cmd_wdata(req1_cmd_wdata), .req1_rsp_valid(req1_rsp_valid),
    .req1_rsp_rdata(req1_rsp_rdata), .req1_rsp_err(req1_rsp_err),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_wdata(mem_cmd_wdata), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic wr; logic [11:0] addr; logic [31:0] wdata; } cmd_t;
  typedef struct { int cyc; int who; logic [31:0] rdata; logic err; } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Requester-side model state
  bit          pend[2];
  logic        wr_r[2];
  logic [11:0] addr_r[2];
  logic [31:0] wd_r[2];
  bit          last_grant = 1'b1;
  int          next_free = 0;
  int          sched_cyc = -100;
  int          late_cyc = -100;
  logic [31:0] sched_data = '0;
  bit          use_fix = 1'b0;
  logic [31:0] fix_val = '0;

  // Expected held command fields, tracked by the monitor
  logic        hold_wr = 1'b0;
  logic [11:0] hold_addr = '0;
  logic [31:0] hold_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    req0_cmd_valid = pend[0]; req0_cmd_wr = wr_r[0]; req0_cmd_addr = addr_r[0]; req0_cmd_wdata = wd_r[0];
    req1_cmd_valid = pend[1]; req1_cmd_wr = wr_r[1]; req1_cmd_addr = addr_r[1]; req1_cmd_wdata = wd_r[1];
    mem_rsp_ready  = (cyc == sched_cyc) || (cyc == late_cyc);
    mem_rsp_rdata  = (cyc == sched_cyc) ? sched_data : $urandom();
  endtask

  task automatic load(input int i, input logic wr, input logic [11:0] addr, input logic [31:0] wd);
    pend[i] = 1'b1; wr_r[i] = wr; addr_r[i] = addr; wd_r[i] = wd;
  endtask

  // One clock cycle: new random requests, drive, then predict the grant and queue expectations.
  task automatic step(input int p_req, input int p_wr, input int p_none, input int max_d);
    bit acc;
    int w;
    int r;
    @(posedge clk); #1; cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && ($urandom_range(0, 99) < p_req))
        load(i, $urandom_range(0, 99) < p_wr, 12'($urandom()), $urandom());
    end
    drive();
    @(negedge clk);
    acc = (cyc >= next_free) && (pend[0] || pend[1]);
    w   = (pend[0] && pend[1]) ? (last_grant ? 0 : 1) : (pend[1] ? 1 : 0);
    check("req0_cmd_ready", req0_cmd_ready, 32'(acc && (w == 0)));
    check("req1_cmd_ready", req1_cmd_ready, 32'(acc && (w == 1)));
    if (acc) begin
      last_grant = (w == 1);
      pend[w] = 1'b0;
      cmd_q.push_back('{cyc + 1, wr_r[w], addr_r[w], wd_r[w]});
      if (wr_r[w]) begin
        next_free = cyc + 2;
      end else if ($urandom_range(0, 99) < p_none) begin
        rsp_q.push_back('{cyc + 1 + TO, w, 32'h0, 1'b1});
        next_free = cyc + 1 + TO;
        late_cyc  = cyc + 1 + TO + int'($urandom_range(0, 1));
      end else begin
        r = (max_d > 1 && $urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(1, max_d));
        sched_cyc  = cyc + 1 + r;
        sched_data = use_fix ? fix_val : $urandom();
        rsp_q.push_back('{sched_cyc + 1, w, sched_data, 1'b0});
        next_free = sched_cyc + 1;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (pend[0] || pend[1] || cyc < next_free || rsp_q.size() > 0); k++)
      step(0, 0, 0, 1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a command or a response.
  initial begin
    cmd_t e;
    rsp_t q;
    logic v;
    forever begin
      @(negedge clk);
      if (reset_) begin
        if (mem_cmd_valid) begin
          if (cmd_q.size() == 0) begin
            check("mem_cmd_valid unexpected", 32'(mem_cmd_valid), 32'h0);
          end else begin
            e = cmd_q.pop_front();
            check("mem_cmd cycle", 32'(cyc), 32'(e.cyc));
            check("mem_cmd_wr", 32'(mem_cmd_wr), 32'(e.wr));
            check("mem_cmd_addr", 32'(mem_cmd_addr), 32'(e.addr));
            check("mem_cmd_wdata", mem_cmd_wdata, e.wdata);
            hold_wr = e.wr; hold_addr = e.addr; hold_wdata = e.wdata;
          end
        end else begin
          check("mem_cmd_addr hold", 32'(mem_cmd_addr), 32'(hold_addr));
          check("mem_cmd_wr/wdata hold", {mem_cmd_wdata[30:0], mem_cmd_wr}, {hold_wdata[30:0], hold_wr});
        end
        while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
          check("mem_cmd_valid missing", 32'h0, 32'h1);
          void'(cmd_q.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
          v = (i == 0) ? req0_rsp_valid : req1_rsp_valid;
          if (v) begin
            if (rsp_q.size() == 0) begin
              check($sformatf("req%0d_rsp_valid unexpected", i), 32'(v), 32'h0);
            end else begin
              q = rsp_q.pop_front();
              check("rsp requester", 32'(i), 32'(q.who));
              check("rsp cycle", 32'(cyc), 32'(q.cyc));
              check("rsp_rdata", (i == 0) ? req0_rsp_rdata : req1_rsp_rdata, q.rdata);
              check("rsp_err", 32'((i == 0) ? req0_rsp_err : req1_rsp_err), 32'(q.err));
            end
          end
        end
        while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
          check("rsp_valid missing", 32'h0, 32'h1);
          void'(rsp_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; wr_r[i] = 1'b0; addr_r[i] = '0; wd_r[i] = '0;
    end
    repeat (3) begin @(posedge clk); #1; cyc++; end
    check("reset mem_cmd_valid", 32'(mem_cmd_valid), 32'h0);
    check("reset rsp_valid", 32'({req0_rsp_valid, req1_rsp_valid}), 32'h0);
    check("reset mem_cmd_addr", 32'(mem_cmd_addr), 32'h0);
    reset_ = 1'b1;
    next_free = cyc;

    // Both requesters hammer reads with prompt responses: strict alternation, 3 cycles apart.
    repeat (20) step(100, 0, 0, 1);
    drain();

    // Single write from req0, then a read from req1 with a known response.
    load(0, 1'b1, 12'h004, 32'h0000_00A5);
    step(0, 0, 0, 1);
    drain();
    use_fix = 1'b1; fix_val = 32'h0000_003C;
    load(1, 1'b0, 12'h00C, 32'h0);
    step(0, 0, 0, 1);
    drain();
    use_fix = 1'b0;

    // Back-to-back writes from req0 with req1 idle.
    load(0, 1'b1, 12'h010, 32'h1111_2222);
    step(0, 0, 0, 1);
    load(0, 1'b1, 12'h014, 32'h3333_4444);
    step(0, 0, 0, 1);
    drain();

    // Read that never gets a response, followed by a late strobe.
    load(0, 1'b0, 12'h020, 32'h0);
    step(0, 0, 100, 1);
    drain();

    // Randomized mix, including timeouts and boundary-latency responses.
    repeat (400) step(40, 40, 10, 6);
    drain();

    // Reset while waiting for a read response.
    load(1, 1'b0, 12'h030, 32'h0);
    step(0, 0, 100, 1);
    repeat (3) step(0, 0, 0, 1);
    @(posedge clk); #1; cyc++;
    reset_ = 1'b0;
    #1;
    check("async reset mem_cmd_valid", 32'(mem_cmd_valid), 32'h0);
    check("async reset mem_cmd fields", {mem_cmd_wdata[19:0], mem_cmd_addr}, 32'h0);
    check("async reset mem_cmd_wr", 32'(mem_cmd_wr), 32'h0);
    check("async reset cmd_ready", 32'({req0_cmd_ready, req1_cmd_ready}), 32'h0);
    check("async reset rsp_valid/err", 32'({req0_rsp_valid, req1_rsp_valid, req0_rsp_err, req1_rsp_err}), 32'h0);
    check("async reset req0_rsp_rdata", req0_rsp_rdata, 32'h0);
    check("async reset req1_rsp_rdata", req1_rsp_rdata, 32'h0);
    rsp_q.delete();
    late_cyc = -100; sched_cyc = -100;
    hold_wr = 1'b0; hold_addr = '0; hold_wdata = '0;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    reset_ = 1'b1;
    last_grant = 1'b1;
    next_free = cyc;
    load(0, 1'b0, 12'h040, 32'h0);
    load(1, 1'b0, 12'h044, 32'h0);
    step(0, 0, 0, 2);
    drain();

    repeat (4) step(0, 0, 0, 1);
    check("cmd queue empty", 32'(cmd_q.size()), 32'h0);
    check("rsp queue empty", 32'(rsp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
